// File: rtl/zion_riscv_branch_resolve.sv
// Branch/jump resolution: decides direction, detects mispredicts and
// drives a handshaked redirect followed by a fixed-length flush.
module zion_riscv_branch_resolve #(
  parameter int CPU_WIDTH = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [2:0]           in_funct3,
  input  logic                 in_is_jump,
  input  logic [CPU_WIDTH-1:0] in_sub_rslt,
  input  logic                 in_lt,
  input  logic                 in_pred_taken,
  input  logic [CPU_WIDTH-1:0] in_pc,
  input  logic [CPU_WIDTH-1:0] in_target,
  output logic                 out_resolve_vld,
  output logic                 out_taken,
  output logic                 out_err,
  output logic                 out_redir_vld,
  input  logic                 out_redir_rdy,
  output logic [CPU_WIDTH-1:0] out_redir_pc,
  output logic                 out_flush,
  output logic [CNT_W-1:0]     out_taken_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_INIT =
    (FLUSH_CYC > 0) ? 4'(FLUSH_CYC - 1) : 4'd0;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           cnt;
  logic [3:0]           cnt_nxt;
  logic                 accept;
  logic                 taken_d;
  logic                 err_d;
  logic                 mispred;
  logic [CPU_WIDTH-1:0] next_pc;

  // Gated by rst so every output reads 0 while reset is held.
  assign in_rdy        = (state == IDLE) && !rst;
  assign accept        = in_vld && in_rdy;
  assign out_redir_vld = (state == REDIR);
  assign out_flush     = (state == FLUSH);

  always_comb begin
    taken_d = 1'b0;
    err_d   = 1'b0;
    if (in_is_jump) begin
      taken_d = 1'b1;
    end else begin
      case (in_funct3)
        3'b000:  taken_d = (in_sub_rslt == '0);
        3'b001:  taken_d = (in_sub_rslt != '0);
        3'b100,
        3'b110:  taken_d = in_lt;
        3'b101,
        3'b111:  taken_d = !in_lt;
        default: err_d   = 1'b1;
      endcase
    end
  end

  assign mispred = (taken_d != in_pred_taken);
  assign next_pc = taken_d ? in_target
                           : in_pc + CPU_WIDTH'(4);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && mispred) state_nxt = REDIR;
      end
      REDIR: begin
        if (out_redir_rdy) begin
          if (FLUSH_CYC > 0) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_INIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      out_redir_pc    <= '0;
      out_resolve_vld <= 1'b0;
      out_taken       <= 1'b0;
      out_err         <= 1'b0;
      out_taken_cnt   <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      out_resolve_vld <= accept;
      out_taken       <= accept && taken_d;
      out_err         <= accept && err_d;
      if (accept && mispred) out_redir_pc <= next_pc;
      if (accept && taken_d && !(&out_taken_cnt))
        out_taken_cnt <= out_taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_zion_riscv_branch_resolve.sv
// Randomized bench for zion_riscv_branch_resolve against an operand-level
// branch model; a second instance covers FLUSH_CYC=0 and a 2-bit counter.
module tb_zion_riscv_branch_resolve;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [2:0]  in_funct3 = '0;
  logic        in_is_jump = 1'b0;
  logic [31:0] in_sub_rslt = '0;
  logic        in_lt = 1'b0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_target = '0;
  logic        out_resolve_vld;
  logic        out_taken;
  logic        out_err;
  logic        out_redir_vld;
  logic        out_redir_rdy = 1'b0;
  logic [31:0] out_redir_pc;
  logic        out_flush;
  logic [15:0] out_taken_cnt;

  logic        b_vld = 1'b0;
  logic        b_rdy;
  logic [31:0] b_pc = '0;
  logic [31:0] b_tgt = '0;
  logic        b_pred = 1'b1;
  logic        b_res;
  logic        b_tk;
  logic        b_err;
  logic        b_rv;
  logic        b_rr = 1'b1;
  logic [31:0] b_rpc;
  logic        b_fl;
  logic [1:0]  b_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cnt_m = 0;

  always #5 clk = ~clk;

  zion_riscv_branch_resolve #(
    .CPU_WIDTH(32), .FLUSH_CYC(FC), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .in_funct3(in_funct3), .in_is_jump(in_is_jump),
    .in_sub_rslt(in_sub_rslt), .in_lt(in_lt),
    .in_pred_taken(in_pred_taken),
    .in_pc(in_pc), .in_target(in_target),
    .out_resolve_vld(out_resolve_vld),
    .out_taken(out_taken), .out_err(out_err),
    .out_redir_vld(out_redir_vld),
    .out_redir_rdy(out_redir_rdy),
    .out_redir_pc(out_redir_pc),
    .out_flush(out_flush),
    .out_taken_cnt(out_taken_cnt)
  );

  zion_riscv_branch_resolve #(
    .CPU_WIDTH(32), .FLUSH_CYC(0), .CNT_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .in_vld(b_vld), .in_rdy(b_rdy),
    .in_funct3(3'b000), .in_is_jump(1'b0),
    .in_sub_rslt(32'd0), .in_lt(1'b0),
    .in_pred_taken(b_pred),
    .in_pc(b_pc), .in_target(b_tgt),
    .out_resolve_vld(b_res),
    .out_taken(b_tk), .out_err(b_err),
    .out_redir_vld(b_rv),
    .out_redir_rdy(b_rr),
    .out_redir_pc(b_rpc),
    .out_flush(b_fl),
    .out_taken_cnt(b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Direction decided straight from the source operands.
  function automatic void ref_op(input logic [2:0] f3,
                                 input logic j,
                                 input logic [31:0] s1,
                                 input logic [31:0] s2,
                                 output logic tk,
                                 output logic er);
    tk = 1'b0;
    er = 1'b0;
    if (j) tk = 1'b1;
    else case (f3)
      3'd0: tk = (s1 == s2);
      3'd1: tk = (s1 != s2);
      3'd4: tk = ($signed(s1) <  $signed(s2));
      3'd5: tk = ($signed(s1) >= $signed(s2));
      3'd6: tk = (s1 <  s2);
      3'd7: tk = (s1 >= s2);
      default: er = 1'b1;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic j,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic pred, input logic [31:0] pc,
                       input logic [31:0] tgt, input int dly,
                       input bit rst_mid);
    logic tk, er, mis;
    logic [31:0] npc;
    ref_op(f3, j, s1, s2, tk, er);
    mis = (tk != pred);
    npc = tk ? tgt : pc + 32'd4;
    chk("rdy_pre", in_rdy, 1);
    in_funct3     = f3;
    in_is_jump    = j;
    in_sub_rslt   = s1 - s2;
    in_lt         = f3[1] ? (s1 < s2)
                          : ($signed(s1) < $signed(s2));
    in_pred_taken = pred;
    in_pc         = pc;
    in_target     = tgt;
    in_vld        = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    if (tk && cnt_m < 65535) cnt_m++;
    chk("resolve", out_resolve_vld, 1);
    chk("taken", out_taken, tk);
    chk("err", out_err, er);
    chk("tcnt", out_taken_cnt, cnt_m);
    chk("redir_vld", out_redir_vld, mis);
    chk("flush0", out_flush, 0);
    if (!mis) return;
    chk("redir_pc", out_redir_pc, npc);
    chk("rdy_redir", in_rdy, 0);
    if (rst_mid) begin
      #2 rst = 1'b1;
      #1;
      chk("rst_rv", out_redir_vld, 0);
      chk("rst_fl", out_flush, 0);
      chk("rst_cnt", out_taken_cnt, 0);
      chk("rst_pc", out_redir_pc, 0);
      chk("rst_res", out_resolve_vld, 0);
      @(negedge clk) rst = 1'b0;
      cnt_m = 0;
      @(posedge clk); #1;
      chk("rst_idle", in_rdy, 1);
      chk("rst_rv2", out_redir_vld, 0);
      return;
    end
    // Junk presented while stalled must be ignored.
    in_vld        = 1'b1;
    in_funct3     = 3'($urandom);
    in_pred_taken = 1'($urandom);
    in_pc         = $urandom;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("stall_vld", out_redir_vld, 1);
      chk("stall_pc", out_redir_pc, npc);
      chk("stall_res", out_resolve_vld, 0);
    end
    out_redir_rdy = 1'b1;
    @(posedge clk); #1;
    out_redir_rdy = 1'b0;
    for (int f = 0; f < FC; f++) begin
      chk("flush", out_flush, 1);
      chk("fl_rv", out_redir_vld, 0);
      chk("fl_rdy", in_rdy, 0);
      chk("fl_res", out_resolve_vld, 0);
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    chk("post_fl", out_flush, 0);
    chk("post_rdy", in_rdy, 1);
    chk("post_res", out_resolve_vld, 0);
  endtask

  initial begin
    logic [31:0] s1, s2, pc;
    #1 rst = 1'b1;
    #2;
    chk("r_res", out_resolve_vld, 0);
    chk("r_tk", out_taken, 0);
    chk("r_err", out_err, 0);
    chk("r_rv", out_redir_vld, 0);
    chk("r_pc", out_redir_pc, 0);
    chk("r_fl", out_flush, 0);
    chk("r_cnt", out_taken_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    do_op(3'b000, 0, 32'd7, 32'd7, 1, 32'h100, 32'h40, 0, 0);
    chk("beq_rdy", in_rdy, 1);
    do_op(3'b110, 0, 32'd5, 32'd3, 1, 32'h200, 32'h80, 3, 0);
    do_op(3'b001, 0, 32'd9, 32'd9, 1, 32'hFFFF_FFFC, 32'h0, 0, 0);
    do_op(3'b010, 0, 32'd1, 32'd2, 0, 32'h300, 32'h10, 0, 0);
    do_op(3'b010, 0, 32'd1, 32'd2, 1, 32'h300, 32'h10, 1, 0);
    do_op(3'b011, 1, 32'd1, 32'd2, 0, 32'h380, 32'h400, 0, 1);

    for (int n = 0; n < 300; n++) begin
      s1 = $urandom;
      s2 = ($urandom_range(0, 3) == 0) ? s1 : $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      do_op(3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0),
            s1, s2, 1'($urandom_range(0, 1)), pc,
            $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3), 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("gap_res", out_resolve_vld, 0);
      end
    end

    for (int k = 0; k < 5; k++) begin
      b_vld = 1'b1;
      @(posedge clk); #1;
      chk("b_res", b_res, 1);
      chk("b_sat", b_cnt, (k + 1 > 3) ? 3 : k + 1);
    end
    b_pred = 1'b0;
    b_tgt  = 32'h500;
    @(posedge clk); #1;
    b_vld = 1'b0;
    chk("b_rv", b_rv, 1);
    chk("b_rpc", b_rpc, 32'h500);
    chk("b_cnt3", b_cnt, 3);
    @(posedge clk); #1;
    chk("b_rv0", b_rv, 0);
    chk("b_fl", b_fl, 0);
    chk("b_rdy", b_rdy, 1);
    @(posedge clk); #1;
    chk("b_fl2", b_fl, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
